md_unit: RTL and testbench

Parametrised multiply/divide unit with HI/LO registers for the pipelined MIPS core. It sits in the E stage beside the ALU and executes mult, multu, div, divu, mfhi, mflo, mthi and mtlo. Multiply and divide take a parameterised number of cycles. While an operation is in flight the unit raises `busy`, and the hazard unit uses it to stall any later HI/LO instruction in D.

---
 rtl/md_unit.sv | 115 +++++++++++
 tb/tb_md_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// HI/LO multiply/divide unit for the E stage.
// Results are computed at launch into shadow registers and committed after N cycles.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       md_op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic [WIDTH-1:0] md_result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] shi_q, slo_q;
  logic [WIDTH-1:0] shi_d, slo_d;
  logic             wr_q;

  logic             is_mul, is_div, is_sgn;
  logic             a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag, b_div;
  logic [WIDTH-1:0] q_mag, r_mag;
  logic [2*WIDTH-1:0] mul_a, mul_b, prod;

  assign is_mul = (md_op == 4'd1) || (md_op == 4'd2);
  assign is_div = (md_op == 4'd3) || (md_op == 4'd4);
  assign is_sgn = (md_op == 4'd1) || (md_op == 4'd3);

  always_comb begin
    mul_a  = is_sgn ? {{WIDTH{srcA[WIDTH-1]}}, srcA} : {{WIDTH{1'b0}}, srcA};
    mul_b  = is_sgn ? {{WIDTH{srcB[WIDTH-1]}}, srcB} : {{WIDTH{1'b0}}, srcB};
    prod   = mul_a * mul_b;
    // Signed divide runs on magnitudes; MIN/-1 falls out as MIN, remainder 0.
    a_neg  = is_sgn && srcA[WIDTH-1];
    b_neg  = is_sgn && srcB[WIDTH-1];
    a_mag  = a_neg ? -srcA : srcA;
    b_mag  = b_neg ? -srcB : srcB;
    b_zero = (srcB == '0);
    b_div  = b_zero ? WIDTH'(1) : b_mag;
    q_mag  = a_mag / b_div;
    r_mag  = a_mag % b_div;
    shi_d  = prod[2*WIDTH-1:WIDTH];
    slo_d  = prod[WIDTH-1:0];
    if (is_div) begin
      shi_d = a_neg ? -r_mag : r_mag;
      slo_d = (a_neg ^ b_neg) ? -q_mag : q_mag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      shi_q   <= '0;
      slo_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (is_mul || is_div) begin
              state_q <= RUN;
              cnt_q   <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
              shi_q   <= shi_d;
              slo_q   <= slo_d;
              wr_q    <= !(is_div && b_zero);
            end else if (md_op == 4'd7) begin
              hi_q <= srcA;
            end else if (md_op == 4'd8) begin
              lo_q <= srcA;
            end
          end
        end
        RUN: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (wr_q) begin
              hi_q <= shi_q;
              lo_q <= slo_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    md_result = '0;
    if (md_op == 4'd5)      md_result = hi_q;
    else if (md_op == 4'd6) md_result = lo_q;
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: default timing plus a 1-cycle instance.
`timescale 1ns/1ps
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] srcA, srcB;
  logic        busy0, busy1;
  logic [31:0] res0, hi0, lo0;
  logic [31:0] res1, hi1, lo1;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) u0 (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .srcA(srcA), .srcB(srcB), .busy(busy0), .md_result(res0),
    .hi(hi0), .lo(lo0)
  );

  md_unit #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)) u1 (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .srcA(srcA), .srcB(srcB), .busy(busy1), .md_result(res1),
    .hi(hi1), .lo(lo1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    start = 1'b1; md_op = op; srcA = a; srcB = b;
    step();
    start = 1'b0; md_op = 4'd0;
  endtask

  task automatic count_busy(input bit which, output int n);
    n = 0;
    while ((which ? busy1 : busy0) && n < 100) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; md_op = 4'd0; srcA = '0; srcB = '0;
    step(); step();
    reset = 1'b0;
    total_cnt++;
    if (busy0 !== 1'b0) $display("FAIL reset_busy got %0h exp 0", busy0);
    else pass_cnt++;
    total_cnt++;
    if (hi0 !== 32'h0) $display("FAIL reset_hi got %h exp 0", hi0);
    else pass_cnt++;
    total_cnt++;
    if (lo0 !== 32'h0) $display("FAIL reset_lo got %h exp 0", lo0);
    else pass_cnt++;
    total_cnt++;
    if (res0 !== 32'h0) $display("FAIL reset_result got %h exp 0", res0);
    else pass_cnt++;
  endtask

  task automatic test_mult();
    int n;
    launch(4'd1, 32'hFFFF_FFFE, 32'd3);
    count_busy(1'b0, n);
    total_cnt++;
    if (n != 5) $display("FAIL mult_busy got %0d exp 5", n);
    else pass_cnt++;
    total_cnt++;
    if (hi0 !== 32'hFFFF_FFFF) $display("FAIL mult_hi got %h exp ffffffff", hi0);
    else pass_cnt++;
    total_cnt++;
    if (lo0 !== 32'hFFFF_FFFA) $display("FAIL mult_lo got %h exp fffffffa", lo0);
    else pass_cnt++;
    md_op = 4'd5; #1;
    total_cnt++;
    if (res0 !== 32'hFFFF_FFFF) $display("FAIL mfhi got %h exp ffffffff", res0);
    else pass_cnt++;
    md_op = 4'd6; #1;
    total_cnt++;
    if (res0 !== 32'hFFFF_FFFA) $display("FAIL mflo got %h exp fffffffa", res0);
    else pass_cnt++;
    md_op = 4'd0;
  endtask

  task automatic test_div();
    int n;
    launch(4'd3, 32'hFFFF_FFF9, 32'd2);
    count_busy(1'b0, n);
    total_cnt++;
    if (n != 10) $display("FAIL div_busy got %0d exp 10", n);
    else pass_cnt++;
    total_cnt++;
    if (lo0 !== 32'hFFFF_FFFD) $display("FAIL div_lo got %h exp fffffffd", lo0);
    else pass_cnt++;
    total_cnt++;
    if (hi0 !== 32'hFFFF_FFFF) $display("FAIL div_hi got %h exp ffffffff", hi0);
    else pass_cnt++;
    launch(4'd4, 32'hFFFF_FFF9, 32'd2);
    count_busy(1'b0, n);
    total_cnt++;
    if (lo0 !== 32'h7FFF_FFFC) $display("FAIL divu_lo got %h exp 7ffffffc", lo0);
    else pass_cnt++;
    total_cnt++;
    if (hi0 !== 32'h1) $display("FAIL divu_hi got %h exp 1", hi0);
    else pass_cnt++;
  endtask

  task automatic test_div_zero();
    int n;
    launch(4'd7, 32'h1234, 32'h0);
    total_cnt++;
    if (hi0 !== 32'h1234 || busy0 !== 1'b0)
      $display("FAIL mthi got hi=%h busy=%0h exp hi=1234 busy=0", hi0, busy0);
    else pass_cnt++;
    launch(4'd3, 32'h55, 32'h0);
    count_busy(1'b0, n);
    total_cnt++;
    if (n != 10) $display("FAIL divz_busy got %0d exp 10", n);
    else pass_cnt++;
    total_cnt++;
    if (hi0 !== 32'h1234) $display("FAIL divz_hi got %h exp 1234", hi0);
    else pass_cnt++;
    total_cnt++;
    if (lo0 !== 32'h7FFF_FFFC) $display("FAIL divz_lo got %h exp 7ffffffc", lo0);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    int n;
    launch(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(1'b0, n);
    total_cnt++;
    if (lo0 !== 32'h8000_0000) $display("FAIL ovf_lo got %h exp 80000000", lo0);
    else pass_cnt++;
    total_cnt++;
    if (hi0 !== 32'h0) $display("FAIL ovf_hi got %h exp 0", hi0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    launch(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    total_cnt++;
    if (busy0 !== 1'b0 || hi0 !== 32'h0 || lo0 !== 32'h0)
      $display("FAIL rstmid got busy=%0h hi=%h lo=%h exp 0/0/0", busy0, hi0, lo0);
    else pass_cnt++;
    repeat (10) step();
    total_cnt++;
    if (busy0 !== 1'b0 || hi0 !== 32'h0 || lo0 !== 32'h0)
      $display("FAIL rstmid_late got busy=%0h hi=%h lo=%h exp 0/0/0", busy0, hi0, lo0);
    else pass_cnt++;
  endtask

  task automatic test_ignored_start();
    int n;
    launch(4'd1, 32'd3, 32'd4);
    start = 1'b1; md_op = 4'd8; srcA = 32'hAA;
    step();
    start = 1'b0; md_op = 4'd0;
    total_cnt++;
    if (lo0 !== 32'h0 || busy0 !== 1'b1)
      $display("FAIL ign_mtlo got lo=%h busy=%0h exp lo=0 busy=1", lo0, busy0);
    else pass_cnt++;
    count_busy(1'b0, n);
    total_cnt++;
    if (n != 4) $display("FAIL ign_busy got %0d exp 4", n);
    else pass_cnt++;
    total_cnt++;
    if (lo0 !== 32'hC || hi0 !== 32'h0)
      $display("FAIL ign_commit got hi=%h lo=%h exp 0/c", hi0, lo0);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int n;
    launch(4'd2, 32'd7, 32'd6);
    total_cnt++;
    if (busy0 !== 1'b1) $display("FAIL b2b_rise got %0h exp 1", busy0);
    else pass_cnt++;
    count_busy(1'b0, n);
    total_cnt++;
    if (n != 5 || lo0 !== 32'h2A || hi0 !== 32'h0)
      $display("FAIL b2b_first got n=%0d lo=%h exp 5/2a", n, lo0);
    else pass_cnt++;
    launch(4'd1, 32'hFFFF_FFFF, 32'h10);
    total_cnt++;
    if (busy0 !== 1'b1) $display("FAIL b2b_chain got %0h exp 1", busy0);
    else pass_cnt++;
    count_busy(1'b0, n);
    total_cnt++;
    if (n != 5 || hi0 !== 32'hFFFF_FFFF || lo0 !== 32'hFFFF_FFF0)
      $display("FAIL b2b_second got n=%0d hi=%h lo=%h exp 5/ffffffff/fffffff0",
               n, hi0, lo0);
    else pass_cnt++;
  endtask

  task automatic test_fast();
    int n;
    launch(4'd1, 32'hFFFF_FFFE, 32'd3);
    count_busy(1'b1, n);
    total_cnt++;
    if (n != 1) $display("FAIL fast_mult_busy got %0d exp 1", n);
    else pass_cnt++;
    total_cnt++;
    if (hi1 !== 32'hFFFF_FFFF || lo1 !== 32'hFFFF_FFFA)
      $display("FAIL fast_mult got hi=%h lo=%h exp ffffffff/fffffffa", hi1, lo1);
    else pass_cnt++;
    launch(4'd4, 32'd100, 32'd7);
    count_busy(1'b1, n);
    total_cnt++;
    if (n != 1) $display("FAIL fast_div_busy got %0d exp 1", n);
    else pass_cnt++;
    total_cnt++;
    if (lo1 !== 32'hE || hi1 !== 32'h2)
      $display("FAIL fast_div got hi=%h lo=%h exp 2/e", hi1, lo1);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_overflow();
    test_reset_mid();
    test_ignored_start();
    test_back_to_back();
    test_fast();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
